mp_ooo_tag_array_ctrl: RTL
==========================

// Module: mp_ooo_tag_array_ctrl
// PURPOSE
//  Parametrised single-port tag store for the mp_ooo caches; replaces the fixed 64x21 tag macro.
//  Adds per-entry valid bits, bit-masked writes, a one-cycle flash invalidate, and a post-reset
//  init sweep that zeroes every entry. The one-cycle read latency of the old macro is kept.
//  Sits between the cache controller FSM and its tag lookup/compare logic.
// PARAMETERS
//  DATA_WIDTH  21                Tag width in bits (>=1).
//  ADDR_WIDTH  6                 Index width; depth = 1<<ADDR_WIDTH.
//  RAM_DEPTH   1<<ADDR_WIDTH     Derived entry count; do not override.
//  INIT_VALUE  {DATA_WIDTH{1'b0}}  Value written to every entry during the init sweep.
// PORTS
//  clk0         in   1            Clock; all state changes on the rising edge.
//  rst0         in   1            Asynchronous, active-high reset.
//  csb0         in   1            Active-low request select.
//  web0         in   1            Active-low write enable (0 = write, 1 = read).
//  addr0        in   ADDR_WIDTH   Entry index.
//  din0         in   DATA_WIDTH   Write data.
//  wmask0       in   DATA_WIDTH   Per-bit write mask (1 = update bit).
//  inv0         in   1            Flash invalidate: clear all valid bits.
//  ready0       out  1            1 = requests accepted; 0 during init sweep.
//  dout0        out  DATA_WIDTH   Tag at the last accepted index.
//  dout_valid0  out  1            Valid bit at the last accepted index.
//  perr0        out  1            Parity error on dout0 (TAG_ARRAY_PARITY_EN only).
// BEHAVIOUR
//  - Reset (async, while rst0=1): FSM=INIT, sweep counter=0, all valid bits=0, addr_reg=0.
//    Outputs during reset: ready0=0, dout0=0, dout_valid0=0, perr0=0.
//  - FSM INIT: writes INIT_VALUE (plus its parity) to entry[cnt] each cycle, cnt++.
//    After the entry at cnt=RAM_DEPTH-1 is written, the FSM moves to IDLE.
//    ready0=1 from the next cycle, i.e. exactly RAM_DEPTH cycles after rst0 falls.
//    While INIT: csb0 and inv0 are ignored; dout0=0, dout_valid0=0, perr0=0.
//  - FSM IDLE: a request is accepted at the edge where csb0=0 and ready0=1; addr_reg<=addr0.
//    Write: mem[a] <= (mem[a] & ~wmask0) | (din0 & wmask0); valid[a] <= 1, even if wmask0=0.
//    Read: memory and valid bits are unchanged.
//  - Read port: dout0 = mem[addr_reg] and dout_valid0 = valid[addr_reg], both combinational.
//    Data therefore appears in the cycle after acceptance, and a write is read back with its
//    new value. Outputs hold until the next accepted request or a state change at addr_reg.
//  - inv0=1 in IDLE: every valid bit is cleared at that edge; tag contents are untouched.
//    inv0 together with an accepted write: all bits clear, then valid[addr0]=1 (write wins).
//    inv0 together with a read: dout_valid0=0 next cycle.
//  - Any rst0 assertion, including mid-sweep or mid-request, aborts and restarts the full sweep.
//  - Index wrap: the sweep counter is ADDR_WIDTH+1 bits, so INIT ends without aliasing index 0.
// CONFIGURATION
//  TAG_ARRAY_PARITY_EN defined:
//    - Each entry stores DATA_WIDTH+1 bits; the extra bit is the even parity of the merged data.
//    - perr0 = ^{mem[addr_reg]} with parity, gated by dout_valid0 and ready0; combinational.
//    - An invalid entry never flags.
//  TAG_ARRAY_PARITY_EN undefined:
//    - No perr0 port; storage is DATA_WIDTH bits; no parity logic.
// TESTING
//  1 rst0 pulse, defaults -> ready0=0 for exactly 64 cycles, then 1; read any index -> dout0=0, dout_valid0=0.
//  2 Write addr0=5, din0=21'h1ABCD, wmask0=all 1s; read 5 -> dout0=21'h1ABCD, dout_valid0=1 the cycle after the read.
//  3 Entry 5 = 21'h1ABCD; write 5 din0=0, wmask0=21'h0000F -> read 5 returns 21'h1ABC0.
//  4 Write 3 and 9; assert inv0 together with a write to 9 -> read 3: valid=0, data kept; read 9: valid=1.
//  5 Assert rst0 at sweep cycle 20, release -> ready0 stays 0 for a full 64 further cycles; all entries read 0.
//  6 (PARITY_EN) Write 7 = 21'h00001; force-flip stored bit 4 -> read 7 gives perr0=1; entry 8 gives perr0=0.

Source files
------------

// File: rtl/mp_ooo_tag_array_ctrl.sv
// Single-port tag store with per-entry valid bits, bit-masked writes, flash invalidate and a post-reset init sweep.
// Optional even parity per entry and the perr0 output are enabled by defining TAG_ARRAY_PARITY_EN.
module mp_ooo_tag_array_ctrl #(
   parameter int unsigned           DATA_WIDTH = 21,
   parameter int unsigned           ADDR_WIDTH = 6,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk0,
   input  logic                  rst0,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] wmask0,
   input  logic                  inv0,
   output logic                  ready0,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic                  dout_valid0
`ifdef TAG_ARRAY_PARITY_EN
   ,
   output logic                  perr0
`endif
);

   localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
`ifdef TAG_ARRAY_PARITY_EN
   localparam int unsigned MEM_W     = DATA_WIDTH + 1;
`else
   localparam int unsigned MEM_W     = DATA_WIDTH;
`endif

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_reg_nxt;
   logic [RAM_DEPTH-1:0]    valid, valid_nxt;
   logic [MEM_W-1:0]        mem [RAM_DEPTH];

   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [MEM_W-1:0]        mem_wdata;
   logic [MEM_W-1:0]        init_word;
   logic [MEM_W-1:0]        wr_word;
   logic [DATA_WIDTH-1:0]   merged;
   logic [MEM_W-1:0]        rd_word;

   // Merge new data into the currently stored tag under the bit mask.
   always_comb begin
      merged = (mem[addr0][DATA_WIDTH-1:0] & ~wmask0) | (din0 & wmask0);
`ifdef TAG_ARRAY_PARITY_EN
      wr_word   = {^merged, merged};
      init_word = {^INIT_VALUE, INIT_VALUE};
`else
      wr_word   = merged;
      init_word = INIT_VALUE;
`endif
   end

   // Next-state: init sweep, then request accept / flash invalidate.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      addr_reg_nxt = addr_reg;
      valid_nxt    = valid;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state)
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_addr  = cnt[ADDR_WIDTH-1:0];
            mem_wdata = init_word;
            valid_nxt = '0;
            cnt_nxt   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(RAM_DEPTH - 1)) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (inv0) begin
               valid_nxt = '0;
            end
            if (!csb0) begin
               addr_reg_nxt = addr0;
               if (!web0) begin
                  mem_we           = 1'b1;
                  mem_addr         = addr0;
                  mem_wdata        = wr_word;
                  valid_nxt[addr0] = 1'b1;
               end
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         state    <= ST_INIT;
         cnt      <= '0;
         addr_reg <= '0;
         valid    <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         addr_reg <= addr_reg_nxt;
         valid    <= valid_nxt;
      end
   end

   // Tag storage carries no reset; the sweep initialises it.
   always_ff @(posedge clk0) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   // Read port is combinational off the registered index; quiet until the sweep completes.
   always_comb begin
      rd_word     = mem[addr_reg];
      ready0      = (state == ST_IDLE);
      dout0       = ready0 ? rd_word[DATA_WIDTH-1:0] : '0;
      dout_valid0 = ready0 & valid[addr_reg];
`ifdef TAG_ARRAY_PARITY_EN
      perr0       = dout_valid0 & (^rd_word);
`endif
   end

endmodule
